// File: rtl/ssd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ssd_arbiter                                                       |
// | Desc    : Round-robin arbiter granting NUM_REQ writers bursts of digit      |
// |           writes into an 8-digit hex display buffer.                        |
// |           Optional macro SSD_ARB_CLEAR_EN adds a synchronous clear port.    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ssd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef SSD_ARB_CLEAR_EN
    input  logic                   clear,
`endif
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [3*NUM_REQ-1:0]   req_idx,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [31:0]            digits_flat,
    output logic                   busy
);

    localparam int c_IDX_W   = (NUM_REQ > 2) ? 2 : 1;
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q;
    logic [c_IDX_W-1:0]     owner_q;
    logic [c_IDX_W-1:0]     last_gnt_q;
    logic [c_BURST_W-1:0]   burst_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     ready_q;
    logic [31:0]            digits_q;

    logic [c_IDX_W-1:0]     win_d;
    logic [NUM_REQ-1:0]     win_oh_d;
    logic [c_BURST_W-1:0]   burst_d;
    logic                   w_any_valid;
    logic                   w_sel_valid;
    logic                   w_sel_ready;
    logic [2:0]             w_sel_idx;
    logic [3:0]             w_sel_data;
    logic                   w_xfer;

    // Descending distance scan so the requester nearest after last_gnt wins.
    always_comb begin
        win_d = last_gnt_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req_valid[r] && (r == ((int'(last_gnt_q) + k) % NUM_REQ))) begin
                    win_d = c_IDX_W'(r);
                end
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            win_oh_d[r] = (win_d == c_IDX_W'(r));
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_ready = 1'b0;
        w_sel_idx   = 3'd0;
        w_sel_data  = 4'd0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_q == c_IDX_W'(r)) begin
                w_sel_valid = req_valid[r];
                w_sel_ready = ready_q[r];
                w_sel_idx   = req_idx[3*r +: 3];
                w_sel_data  = req_data[4*r +: 4];
            end
        end
    end

    assign w_any_valid = |req_valid;
    assign w_xfer      = (state_q == BUSY) && w_sel_valid && w_sel_ready;
    assign burst_d     = burst_q + c_BURST_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_gnt_q <= c_IDX_W'(NUM_REQ - 1);
            burst_q    <= '0;
            grant_q    <= '0;
            ready_q    <= '0;
            digits_q   <= 32'h0;
        end else begin
`ifdef SSD_ARB_CLEAR_EN
            // Clear first so a same-cycle transfer still lands its digit.
            if (clear) begin
                digits_q <= 32'h0;
            end
`endif
            if (w_xfer) begin
                digits_q[{w_sel_idx, 2'b00} +: 4] <= w_sel_data;
            end
            case (state_q)
                IDLE: begin
                    if (w_any_valid) begin
                        state_q <= BUSY;
                        owner_q <= win_d;
                        grant_q <= win_oh_d;
                        ready_q <= win_oh_d;
                        burst_q <= '0;
                    end
                end
                BUSY: begin
                    if (w_xfer) begin
                        burst_q <= burst_d;
                        if (burst_d == c_BURST_LAST) begin
                            state_q    <= IDLE;
                            grant_q    <= '0;
                            ready_q    <= '0;
                            last_gnt_q <= owner_q;
                        end
                    end else begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        ready_q    <= '0;
                        last_gnt_q <= owner_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    ready_q <= '0;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign grant       = grant_q;
    assign digits_flat = digits_q;
    assign busy        = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_ssd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ssd_arbiter                                                    |
// | Desc    : Directed self-checking bench for ssd_arbiter (NUM_REQ=2,          |
// |           MAX_BURST=8); clear scenario built when SSD_ARB_CLEAR_EN is set.  |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ssd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [5:0]  req_idx;
    logic [7:0]  req_data;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [31:0] digits_flat;
    logic        busy;
`ifdef SSD_ARB_CLEAR_EN
    logic        clear;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ssd_arbiter #(
        .NUM_REQ   (2),
        .MAX_BURST (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef SSD_ARB_CLEAR_EN
        .clear       (clear),
`endif
        .req_valid   (req_valid),
        .req_idx     (req_idx),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant       (grant),
        .digits_flat (digits_flat),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        step();
        reset = 1'b0;
    endtask

    logic [1:0] eg;

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_idx   = 6'd0;
        req_data  = 8'd0;
`ifdef SSD_ARB_CLEAR_EN
        clear     = 1'b0;
`endif
        step();
        step();
        check("rst_grant",  {30'd0, grant},     32'd0);
        check("rst_ready",  {30'd0, req_ready}, 32'd0);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_digits", digits_flat,        32'h0);
        reset = 1'b0;
        step();
        check("idle_grant", {30'd0, grant},     32'd0);

        // Single write from requester 0
        req_valid = 2'b01;
        req_idx[2:0]  = 3'd3;
        req_data[3:0] = 4'hA;
        step();
        check("one_grant",  {30'd0, grant},     32'd1);
        check("one_ready",  {30'd0, req_ready}, 32'd1);
        check("one_busy",   {31'd0, busy},      32'd1);
        check("one_nowr",   digits_flat,        32'h0);
        step();
        check("one_digits", digits_flat,        32'h0000A000);
        req_valid = 2'b00;
        step();
        check("one_release", {30'd0, grant},    32'd0);
        check("one_hold",   digits_flat,        32'h0000A000);

        // Both requesters continuously valid: two full bursts
        do_reset();
        step();
        req_valid = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            req_idx[2:0]  = 3'(c);
            req_data[3:0] = 4'(c);
            req_idx[5:3]  = 3'(c);
            req_data[7:4] = 4'(c) ^ 4'hF;
            step();
            if (c <= 8)       eg = 2'b01;
            else if (c == 9)  eg = 2'b00;
            else if (c <= 17) eg = 2'b10;
            else if (c == 18) eg = 2'b00;
            else              eg = 2'b01;
            check($sformatf("rr_grant_c%0d", c), {30'd0, grant},     {30'd0, eg});
            check($sformatf("rr_ready_c%0d", c), {30'd0, req_ready}, {30'd0, eg});
            if (c == 2)  check("rr_dig_c2",  digits_flat, 32'h00000200);
            if (c == 9)  check("rr_dig_c9",  digits_flat, 32'h76543298);
            if (c == 10) check("rr_dig_c10", digits_flat, 32'h76543298);
            if (c == 18) check("rr_dig_c18", digits_flat, 32'h01234DEF);
        end

        // Requester 0 drops after three writes
        do_reset();
        step();
        for (int c = 1; c <= 14; c++) begin
            req_valid     = {1'b1, (c <= 4)};
            req_idx[2:0]  = 3'(c + 3);
            req_data[3:0] = 4'(c - 1);
            req_idx[5:3]  = 3'd0;
            req_data[7:4] = 4'(c);
            step();
            if (c <= 4)       eg = 2'b01;
            else if (c == 5)  eg = 2'b00;
            else if (c <= 13) eg = 2'b10;
            else              eg = 2'b00;
            check($sformatf("drop_grant_c%0d", c), {30'd0, grant}, {30'd0, eg});
            if (c == 5)  check("drop_dig_c5",  digits_flat, 32'h32100000);
            if (c == 14) check("drop_dig_c14", digits_flat, 32'h3210000E);
        end

        // Reset during the fourth transfer of a burst
        do_reset();
        step();
        req_valid = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            req_idx[2:0]  = 3'(c);
            req_data[3:0] = 4'(c);
            step();
        end
        check("abort_pre", digits_flat, 32'h00043200);
        req_idx[2:0]  = 3'd5;
        req_data[3:0] = 4'h7;
        reset = 1'b1;
        step();
        check("abort_digits", digits_flat,        32'h0);
        check("abort_grant",  {30'd0, grant},     32'd0);
        check("abort_ready",  {30'd0, req_ready}, 32'd0);
        check("abort_busy",   {31'd0, busy},      32'd0);
        reset     = 1'b0;
        req_valid = 2'b11;
        step();
        check("abort_next_grant", {30'd0, grant}, 32'd1);
        check("abort_dig5",       digits_flat,    32'h0);

        // Non-granted requester is ignored
        do_reset();
        step();
        req_valid = 2'b01;
        req_idx   = {3'd0, 3'd1};
        req_data  = {4'hF, 4'h9};
        step();
        check("ign_grant", {30'd0, grant}, 32'd1);
        req_valid = 2'b11;
        step();
        check("ign_ready_a", {30'd0, req_ready}, 32'd1);
        step();
        check("ign_ready_b", {30'd0, req_ready}, 32'd1);
        check("ign_digits",  digits_flat,        32'h00000090);
        req_valid = 2'b10;
        step();
        check("ign_release", {30'd0, grant},     32'd0);
        check("ign_dig_rel", digits_flat,        32'h00000090);
        step();
        check("ign_r1_grant", {30'd0, grant},    32'd2);
        req_valid = 2'b00;
        step();
        check("ign_r1_nowr", digits_flat,        32'h00000090);
        check("ign_r1_idle", {30'd0, grant},     32'd0);

`ifdef SSD_ARB_CLEAR_EN
        // Clear colliding with a transfer
        do_reset();
        step();
        req_valid = 2'b01;
        for (int c = 1; c <= 9; c++) begin
            req_idx[2:0]  = 3'(c - 2);
            req_data[3:0] = 4'(10 - c);
            step();
        end
        check("clr_pre", digits_flat, 32'h12345678);
        step();
        check("clr_grant", {30'd0, grant}, 32'd1);
        req_idx[2:0]  = 3'd2;
        req_data[3:0] = 4'hF;
        clear = 1'b1;
        step();
        clear = 1'b0;
        req_valid = 2'b00;
        check("clr_digits", digits_flat,    32'h00000F00);
        check("clr_grant_kept", {30'd0, grant}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_arbiter.md
SSD_ARBITER -- requirements
Module: ssd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing the 8-digit display (legal 2..4).
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum digit writes per grant (legal 1..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-006 SHALL have port req_idx  input  3*NUM_REQ  digit index; requester r uses bits [3r+2:3r].
REQ-007 SHALL have port req_data  input  4*NUM_REQ  hex nibble; requester r uses bits [4r+3:4r].
REQ-008 SHALL have port req_ready  output  NUM_REQ  registered; high only for the granted requester in BUSY.
REQ-009 SHALL have port grant  output  NUM_REQ  registered one-hot owner; all-zero in IDLE.
REQ-010 SHALL have port digits_flat  output  32  display buffer; digit i at bits [4i+3:4i], fed to the scan controller.
REQ-011 SHALL have port busy  output  1  high when state is BUSY.

Function
REQ-012 SHALL implement FSM states IDLE and BUSY.
REQ-013 IDLE: if any req_valid high, SHALL select winner round-robin, searching from last_gnt+1 upward with wrap to 0, and enter BUSY next cycle with grant/req_ready set for winner.
REQ-014 IDLE with no req_valid SHALL remain IDLE, grant=0, req_ready=0.
REQ-015 Transfer SHALL occur when req_valid[r] & req_ready[r] on a clock edge; only the granted requester can transfer.
REQ-016 A transfer SHALL write req_data of the granted requester into digit req_idx; new value visible on digits_flat the following cycle (1-cycle latency).
REQ-017 Undriven digits SHALL hold their last value.
REQ-018 Burst counter SHALL reset to 0 on entry to BUSY and increment per transfer.
REQ-019 On the transfer that makes the count equal MAX_BURST, SHALL return to IDLE next cycle, deasserting grant and req_ready.
REQ-020 In BUSY with granted req_valid low, SHALL return to IDLE next cycle with no write.
REQ-021 On leaving BUSY, last_gnt SHALL be set to the released requester index.
REQ-022 Minimum one IDLE cycle SHALL separate consecutive grants, including to the same requester.
REQ-023 Non-granted requesters' valid/idx/data SHALL be ignored; their req_ready stays 0.
REQ-024 Index arithmetic SHALL be 3-bit unsigned; all 8 indices legal, no out-of-range case.

Reset
REQ-025 On reset high at a clock edge, SHALL force: state IDLE, grant=0, req_ready=0, busy=0, burst count 0, digits_flat=32'h0, last_gnt=NUM_REQ-1 (requester 0 first priority).
REQ-026 Reset asserted mid-burst SHALL abort the burst; any transfer in that cycle SHALL be discarded.

Configuration
REQ-027 Macro SSD_ARB_CLEAR_EN SHALL, when defined, add port clear  input  1; clear high at an edge zeroes all 8 digits without affecting FSM, grant, or burst count.
REQ-028 With SSD_ARB_CLEAR_EN defined, clear and a transfer in the same cycle SHALL result in the transferred digit holding the new data and all other digits zero.
REQ-029 Without SSD_ARB_CLEAR_EN, SHALL have no clear port; digits change only by transfer or reset.

Verification
REQ-030 Reset then req_valid=01, idx0=3, data0=4'hA held 1 write -> grant=01 one cycle after valid, digits_flat=32'h0000A000 one cycle after transfer.
REQ-031 Both valid continuously, MAX_BURST=8 -> grant sequence 01 (8 writes), IDLE 1 cycle, 10 (8 writes), IDLE, 01; no write lost or duplicated.
REQ-032 Requester 0 drops valid after 3 writes while requester 1 valid -> IDLE next cycle, then grant=10; burst count restarts at 0.
REQ-033 Reset asserted on 4th transfer of a burst writing idx5=4'h7 -> digits_flat=0, grant=0, digit5 stays 0; next grant goes to requester 0.
REQ-034 SSD_ARB_CLEAR_EN defined, digits=32'h12345678, clear with transfer idx2=4'hF -> digits_flat=32'h00000F00.
REQ-035 Requester 1 drives idx/data with valid while requester 0 granted -> digits only reflect requester 0 writes, req_ready[1]=0 throughout.
